// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module   : dcache_controller
// Brief    : Direct-mapped write-back/write-allocate data cache with miss stall
// Revision : 1.0
// ============================================================================
module dcache_controller #(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = 256,
    parameter int TAG_W     = 22
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          p1_addr_i,
    input  logic [31:0]          p1_data_i,
    input  logic                 p1_MemRead_i,
    input  logic                 p1_MemWrite_i,
    output logic [31:0]          p1_data_o,
    output logic                 p1_stall_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int c_OFF_W  = $clog2(LINE_BITS / 8);
    localparam int c_IDX_W  = $clog2(NUM_LINES);
    localparam int c_WSEL_W = $clog2(LINE_BITS / 32);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MISS      = 2'd1,
        S_WRITEBACK = 2'd2,
        S_ALLOCATE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [NUM_LINES-1:0]   r_valid;
    logic [NUM_LINES-1:0]   r_dirty;
    logic [TAG_W-1:0]       r_tag  [NUM_LINES];
    logic [LINE_BITS-1:0]   r_data [NUM_LINES];

    logic [c_IDX_W-1:0]     w_idx;
    logic [TAG_W-1:0]       w_tag;
    logic [c_WSEL_W-1:0]    w_word;
    logic [LINE_BITS-1:0]   w_line;
    logic [31:0]            w_rd_word;
    logic                   w_req;
    logic                   w_hit;
    logic                   w_idle_hit;
    logic                   w_unused;

    assign w_idx      = p1_addr_i[c_OFF_W +: c_IDX_W];
    assign w_tag      = p1_addr_i[c_OFF_W + c_IDX_W +: TAG_W];
    assign w_word     = p1_addr_i[2 +: c_WSEL_W];
    assign w_unused   = ^p1_addr_i[1:0];

    assign w_line     = r_data[w_idx];
    assign w_rd_word  = w_line[{w_word, 5'b0} +: 32];
    assign w_req      = p1_MemRead_i | p1_MemWrite_i;
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_idle_hit = (r_state == S_IDLE) && w_hit;

    assign p1_stall_o   = w_req && !w_idle_hit;
    assign p1_data_o    = (w_idle_hit && p1_MemRead_i) ? w_rd_word : 32'd0;
    assign mem_enable_o = (r_state == S_WRITEBACK) || (r_state == S_ALLOCATE);
    assign mem_write_o  = (r_state == S_WRITEBACK);
    assign mem_data_o   = (r_state == S_WRITEBACK) ? w_line : '0;

    // Writeback targets the victim's address; refill targets the requester's.
    always_comb begin
        mem_addr_o = 32'd0;
        case (r_state)
            S_WRITEBACK: mem_addr_o = {r_tag[w_idx], w_idx, {c_OFF_W{1'b0}}};
            S_ALLOCATE:  mem_addr_o = {w_tag, w_idx, {c_OFF_W{1'b0}}};
            default:     mem_addr_o = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (!w_hit) begin
                            r_state <= S_MISS;
                        end else if (p1_MemWrite_i) begin
                            r_dirty[w_idx] <= 1'b1;
                        end
                    end
                end
                S_MISS: begin
                    r_state <= (r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_ALLOCATE;
                end
                S_WRITEBACK: begin
                    if (mem_ack_i) begin
                        r_state <= S_ALLOCATE;
                    end
                end
                S_ALLOCATE: begin
                    if (mem_ack_i) begin
                        r_state        <= S_IDLE;
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag/data storage needs no reset; an ack landing on a reset edge is dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if ((r_state == S_ALLOCATE) && mem_ack_i) begin
                r_data[w_idx] <= mem_data_i;
                r_tag[w_idx]  <= w_tag;
            end else if (w_idle_hit && p1_MemWrite_i) begin
                r_data[w_idx][{w_word, 5'b0} +: 32] <= p1_data_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_controller
// Brief    : Randomized self-checking bench with a transaction-level cache model
// Revision : 1.0
// ============================================================================
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  p1_addr_i;
    logic [31:0]  p1_data_i;
    logic         p1_MemRead_i;
    logic         p1_MemWrite_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    always #5 clk_i = ~clk_i;

    dcache_controller dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .p1_addr_i     (p1_addr_i),
        .p1_data_i     (p1_data_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i)
    );

    // Reference cache contents and backing memory (keyed by line number).
    bit           m_valid [32];
    bit           m_dirty [32];
    logic [21:0]  m_tag   [32];
    logic [255:0] m_line  [32];
    logic [255:0] mem     [int unsigned];

    int           n_vec = 0;
    int           n_err = 0;
    bit           chk_en = 1'b0;

    logic         e_stall, e_en, e_we;
    logic [31:0]  e_rdata, e_maddr;
    logic [255:0] e_mdata;

    int           stall_cnt;
    logic [31:0]  last_rdata;
    logic [31:0]  wb_addr;
    logic [255:0] wb_data;
    logic [255:0] tmp_line;
    logic [31:0]  r_addr;
    logic [21:0]  r_tag;
    logic [4:0]   r_idx;
    logic [2:0]   r_w;
    int           r_op;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("stall",      p1_stall_o,   e_stall);
            check("load_data",  p1_data_o,    e_rdata);
            check("mem_enable", mem_enable_o, e_en);
            check("mem_write",  mem_write_o,  e_we);
            check("mem_addr",   mem_addr_o,   e_maddr);
            check("mem_data",   mem_data_o,   e_mdata);
        end
    end

    function automatic logic [255:0] mem_rd(input int unsigned ln);
        logic [255:0] l;
        if (mem.exists(ln)) return mem[ln];
        for (int j = 0; j < 8; j++) l[j*32 +: 32] = ln * 32'h0100_0193 + j * 32'h1111_1111 + 32'h5A;
        return l;
    endfunction

    function automatic logic [255:0] rnd_line();
        logic [255:0] l;
        for (int j = 0; j < 8; j++) l[j*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic set_exp(input logic s, input logic [31:0] rd, input logic en, input logic we,
                           input logic [31:0] a, input logic [255:0] d);
        e_stall = s; e_rdata = rd; e_en = en; e_we = we; e_maddr = a; e_mdata = d;
    endtask

    // One cycle: sample observables mid-cycle, return just after the next edge.
    task automatic tick();
        @(negedge clk_i);
        if (p1_stall_o) stall_cnt++;
        if (mem_enable_o && mem_write_o) begin
            wb_addr = mem_addr_o;
            wb_data = mem_data_o;
        end
        last_rdata = p1_data_o;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
            p1_addr_i = $urandom; p1_data_i = $urandom;
            mem_ack_i = ($urandom_range(0, 3) == 0);
            mem_data_i = rnd_line();
            set_exp(0, 0, 0, 0, 0, 0);
            tick();
        end
        mem_ack_i = 1'b0;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst_i = 1'b1; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0; mem_ack_i = 1'b0;
        p1_addr_i = 0; p1_data_i = 0; mem_data_i = 0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        for (int i = 0; i < 32; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
        chk_en = 1'b1;
    endtask

    // Full access: miss sequence (if any) then the completing hit cycle.
    // lat_al > 0 forces the refill ack on that ALLOCATE cycle.
    task automatic do_access(input logic [31:0] addr, input bit rd, input bit wr,
                             input logic [31:0] wd, input int lat_al);
        int          idx, w, lwb, lal;
        logic [21:0] tag;
        logic [31:0] la;
        bit          hit;
        idx = int'(addr[9:5]); tag = addr[31:10]; w = int'(addr[4:2]);
        hit = m_valid[idx] && (m_tag[idx] == tag);
        p1_addr_i = addr; p1_MemRead_i = rd; p1_MemWrite_i = wr; p1_data_i = wd;
        mem_ack_i = 1'b0;
        stall_cnt = 0;
        if (!hit) begin
            lal = (lat_al > 0) ? lat_al : $urandom_range(1, 5);
            lwb = $urandom_range(1, 5);
            set_exp(1, 0, 0, 0, 0, 0);
            tick();
            tick();
            if (m_valid[idx] && m_dirty[idx]) begin
                la = {m_tag[idx], addr[9:5], 5'b0};
                for (int k = 1; k <= lwb; k++) begin
                    set_exp(1, 0, 1, 1, la, m_line[idx]);
                    mem_ack_i = (k == lwb); mem_data_i = rnd_line();
                    tick();
                end
                mem[la >> 5] = m_line[idx];
            end
            la = {tag, addr[9:5], 5'b0};
            for (int k = 1; k <= lal; k++) begin
                set_exp(1, 0, 1, 0, la, 0);
                mem_ack_i = (k == lal);
                mem_data_i = (k == lal) ? mem_rd(la >> 5) : rnd_line();
                tick();
            end
            m_line[idx] = mem_rd(la >> 5); m_tag[idx] = tag;
            m_valid[idx] = 1; m_dirty[idx] = 0;
            mem_ack_i = 1'b0;
        end
        set_exp(0, rd ? m_line[idx][w*32 +: 32] : 32'd0, 0, 0, 0, 0);
        tick();
        if (wr) begin
            m_line[idx][w*32 +: 32] = wd;
            m_dirty[idx] = 1;
        end
        p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    endtask

    initial begin
        do_reset();
        idle(10);

        // Cold read miss: ack 10 cycles after the request -> 11 stalled cycles.
        tmp_line = mem_rd(2); tmp_line[63:32] = 32'hDEAD_BEEF; mem[2] = tmp_line;
        do_access(32'h0000_0044, 1, 0, 0, 9);
        check("cold_stall_cycles", stall_cnt, 11);
        check("cold_rdata", last_rdata, 32'hDEAD_BEEF);

        do_access(32'h0000_0048, 0, 1, 32'h1234_5678, 0);
        check("wr_hit_stall_cycles", stall_cnt, 0);
        do_access(32'h0000_0048, 1, 0, 0, 0);
        check("rd_after_wr", last_rdata, 32'h1234_5678);

        // Dirty eviction of line 2, then re-fetch shows the written word survived.
        wb_addr = 0; wb_data = 0;
        do_access(32'h0000_0448, 1, 0, 0, 0);
        check("evict_wb_addr", wb_addr, 32'h0000_0040);
        check("evict_wb_word2", wb_data[95:64], 32'h1234_5678);
        wb_addr = 0;
        do_access(32'h0000_0048, 1, 0, 0, 0);
        check("clean_no_wb", wb_addr, 0);
        check("refetch_rdata", last_rdata, 32'h1234_5678);

        // Store miss allocates and merges, later eviction writes it back.
        do_access(32'h0000_0080, 0, 1, 32'hA5A5_A5A5, 0);
        wb_addr = 0; wb_data = 0;
        do_access(32'h0000_0480, 1, 0, 0, 0);
        check("store_alloc_wb_addr", wb_addr, 32'h0000_0080);
        check("store_alloc_wb_word0", wb_data[31:0], 32'hA5A5_A5A5);
        idle(3);

        // Reset during the third ALLOCATE cycle, then the same read misses again.
        p1_addr_i = 32'h0000_0104; p1_MemRead_i = 1'b1; p1_MemWrite_i = 1'b0; mem_ack_i = 1'b0;
        set_exp(1, 0, 0, 0, 0, 0);
        tick();
        tick();
        for (int k = 1; k <= 3; k++) begin
            set_exp(1, 0, 1, 0, 32'h0000_0100, 0);
            if (k == 3) rst_i = 1'b1;
            tick();
        end
        rst_i = 1'b0;
        for (int i = 0; i < 32; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
        do_access(32'h0000_0104, 1, 0, 0, 4);
        check("post_reset_stall_cycles", stall_cnt, 6);
        idle(2);

        // Randomized traffic over a small tag/index space to force hits and evictions.
        for (int i = 0; i < 300; i++) begin
            r_tag = 22'($urandom_range(0, 3));
            r_idx = 5'($urandom_range(0, 3));
            r_w   = 3'($urandom_range(0, 7));
            r_addr = {r_tag, r_idx, r_w, 2'($urandom_range(0, 3))};
            r_op = $urandom_range(0, 9);
            do_access(r_addr, (r_op < 5) || (r_op == 9), r_op >= 5, $urandom, 0);
            idle($urandom_range(0, 2));
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the EX/MEM pipeline register and the backing data memory.
- Serves word loads/stores from the MEM stage in the same cycle on a hit.
- On a miss, asserts a stall that freezes the pipeline while it performs line writeback and refill over a handshaked, multi-cycle memory interface.

Parameters:
- NUM_LINES, 32, number of cache lines (power of 2); index = addr[9:5] at default.
- LINE_BITS, 256, line size in bits (32 bytes, 8 words); offset word select = addr[4:2].
- TAG_W, 22, tag width = addr[31:10] at defaults.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- p1_addr_i  in  32  byte address from EX/MEM ALU result; addr[1:0] ignored.
- p1_data_i  in  32  store data from EX/MEM.
- p1_MemRead_i  in  1  load request.
- p1_MemWrite_i  in  1  store request.
- p1_data_o  out  32  load data to MEM/WB.
- p1_stall_o  out  1  pipeline stall request.
- mem_addr_o  out  32  line address to memory, bits [4:0] always 0.
- mem_data_o  out  256  line data for writeback.
- mem_enable_o  out  1  memory request valid.
- mem_write_o  out  1  1 = line write, 0 = line read.
- mem_data_i  in  256  refill line data, valid with mem_ack_i.
- mem_ack_i  in  1  one-cycle completion pulse from memory.

Behaviour:
- Storage: per line {valid, dirty, tag[TAG_W-1:0], data[LINE_BITS-1:0]}.
- hit = valid[idx] && tag[idx]==addr tag; req = MemRead || MemWrite. Both asserted together is treated as a store.
- FSM states: IDLE, MISS, WRITEBACK, ALLOCATE.
- IDLE:
  - Hit read: p1_data_o = word addr[4:2] of the line, combinational; stall 0.
  - Hit write: at the clock edge, write the word and set dirty; stall 0.
  - Miss: stall 1 combinationally; next state MISS; no array update.
- MISS (1 cycle): if valid && dirty, go to WRITEBACK, else go to ALLOCATE.
- WRITEBACK:
  - mem_enable 1, mem_write 1, mem_addr = {old tag, idx, 5'b0}, mem_data_o = stored line.
  - Hold until mem_ack_i, then go to ALLOCATE.
- ALLOCATE:
  - mem_enable 1, mem_write 0, mem_addr = {p1 tag, idx, 5'b0}.
  - On mem_ack_i: line = mem_data_i, tag = p1 tag, valid 1, dirty 0; go to IDLE.
- After ALLOCATE the access is a hit in IDLE and completes there (a store merges its word and sets dirty that cycle).
- p1_stall_o = req && !(state==IDLE && hit), combinational. Asserted from the miss cycle through the ALLOCATE ack cycle, deasserted in the IDLE hit cycle.
- Miss latency:
  - Clean miss: 1 (MISS) + N_ack cycles in ALLOCATE; the access completes 1 cycle later.
  - Dirty miss: adds the WRITEBACK ack latency.
- Upstream holds p1_* stable while stall is 1; the block does not re-sample the address mid-miss.
- mem_enable_o/mem_write_o/mem_addr_o are combinational from state. mem_enable drops the cycle after ack.
- mem_ack_i outside WRITEBACK/ALLOCATE is ignored.
- p1_data_o = 0 when not (IDLE && hit && MemRead). mem_data_o = 0 outside WRITEBACK.
- No req: stall 0, no state change, arrays untouched.
- Reset values:
  - state IDLE; all valid/dirty cleared; tags/data don't-care.
  - p1_stall_o 0, p1_data_o 0, mem_enable_o 0, mem_write_o 0, mem_addr_o 0, mem_data_o 0.
- Reset mid-transaction: FSM returns to IDLE at that edge, and in-flight dirty data is discarded. The memory model must tolerate enable dropping before ack.

Test Plan:
- Idle: after reset, no requests for 10 cycles -> p1_stall_o 0, mem_enable_o 0, p1_data_o 0.
- Cold read miss:
  - Stimulus: MemRead addr 0x0000_0044; memory acks after 10 cycles with line word1=0xDEADBEEF.
  - Required: mem_addr_o 0x0000_0040, mem_write_o 0, stall for 11 cycles, then p1_data_o 0xDEADBEEF with stall 0.
- Write hit then read:
  - Stimulus: MemWrite 0x48 data 0x12345678 (line resident), then MemRead 0x48.
  - Required: no stall, no mem_enable, read returns 0x12345678.
- Dirty eviction:
  - Stimulus: after the previous scenario, MemRead 0x0000_0448 (same idx 2, tag 1).
  - Required: WRITEBACK to addr 0x40 with mem_data_o word2=0x12345678, then ALLOCATE addr 0x440, then data word2 of the new line; dirty cleared.
- Store miss allocate: MemWrite 0x80 data 0xA5A5A5A5 on a clean miss -> refill from 0x80, merge word0, dirty set; a later eviction writes back 0xA5A5A5A5.
- Reset mid-ALLOCATE: assert rst_i in the 3rd ALLOCATE cycle -> next cycle state IDLE, mem_enable_o 0, the same read misses again.
